// File: rtl/rdxbar_out_arbiter.sv
// Per-output round-robin packet arbiter for the read-data crossbar.
// Packet locking is compiled in with `define RDXBAR_ARB_PKT_LOCK_EN.
module rdxbar_out_arbiter #(
  parameter int N             = 16,
  parameter int AW            = 4,
  parameter int PORT_ID       = 0,
  parameter int MAX_PKT_BEATS = 64
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [N-1:0]         iReqVld,
  input  logic [N*AW-1:0]      iReqDst,
  input  logic [N-1:0]         iReqLast,
  input  logic                 iOutRdy,
  output logic [N-1:0]         oGnt,
  output logic [$clog2(N)-1:0] oGntIdx,
  output logic                 oGntVld,
  output logic                 oLocked,
  output logic                 oPktOvf
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_PKT_BEATS + 1);

  function automatic logic [IW-1:0] inc_idx(
    input logic [IW-1:0] x
  );
    return (x == IW'(N - 1)) ? '0 : x + IW'(1);
  endfunction

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  logic [N-1:0]  qual;
  logic [IW-1:0] win;
  logic          found;
  logic [IW:0]   scan;

  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  logic          gnt_vld;
  logic          hs;
  logic          locked;

  // Rotating scan starting at ptr; first qualified requester wins.
  always_comb begin
    qual  = '0;
    win   = '0;
    found = 1'b0;
    scan  = '0;
    for (int i = 0; i < N; i++) begin
      qual[i] = iReqVld[i] &&
                (iReqDst[i*AW +: AW] == AW'(PORT_ID));
    end
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(N)) begin
        scan = scan - (IW+1)'(N);
      end
      if (!found && qual[scan[IW-1:0]]) begin
        found = 1'b1;
        win   = scan[IW-1:0];
      end
    end
  end

`ifdef RDXBAR_ARB_PKT_LOCK_EN

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] owner_d;
  logic [CW-1:0] beat_q;
  logic [CW-1:0] beat_d;
  logic          ovf_q;
  logic          ovf_d;

  // While locked the owner keeps the grant even with Vld low.
  always_comb begin
    locked = (state_q == S_LOCK);
    if (locked) begin
      gnt_idx = owner_q;
      gnt_any = 1'b1;
      gnt_vld = iReqVld[owner_q];
    end else begin
      gnt_idx = win;
      gnt_any = found;
      gnt_vld = found;
    end
    if (iRst) begin
      locked  = 1'b0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      gnt_vld = 1'b0;
    end
  end

  assign hs = gnt_vld && iOutRdy;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    ovf_d   = ovf_q;
    if (hs) begin
      unique case (state_q)
        S_IDLE: begin
          if (iReqLast[win]) begin
            ptr_d = inc_idx(win);
          end else begin
            state_d = S_LOCK;
            owner_d = win;
            beat_d  = CW'(1);
          end
        end
        S_LOCK: begin
          if (iReqLast[owner_q]) begin
            state_d = S_IDLE;
            ptr_d   = inc_idx(owner_q);
            beat_d  = '0;
          end else if (beat_q + CW'(1) ==
                       CW'(MAX_PKT_BEATS)) begin
            state_d = S_IDLE;
            ptr_d   = inc_idx(owner_q);
            beat_d  = '0;
            ovf_d   = 1'b1;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      beat_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oLocked = locked;
  assign oPktOvf = ovf_q;

`else

  logic unused_last;

  // Beat-level arbitration: every handshake advances the pointer.
  always_comb begin
    locked  = 1'b0;
    gnt_idx = win;
    gnt_any = found;
    gnt_vld = found;
    if (iRst) begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      gnt_vld = 1'b0;
    end
  end

  assign hs          = gnt_vld && iOutRdy;
  assign unused_last = ^iReqLast;

  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      ptr_d = inc_idx(win);
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign oLocked = locked;
  assign oPktOvf = 1'b0;

`endif

  always_comb begin
    oGnt = '0;
    if (gnt_any) begin
      oGnt[gnt_idx] = 1'b1;
    end
  end

  assign oGntIdx = gnt_idx;
  assign oGntVld = gnt_vld;

endmodule
